fifo_ctrl: RTL and testbench

Single-clock pointer and flag controller for the project's 8-bit FIFO memory array. It accepts write/read requests, generates the memory write enable, and drives the write and read pointers with wrap-around at a non-power-of-two depth. It keeps the occupancy count and full/empty status, and produces a read-valid strobe aligned to the memory's registered read data. Clock and reset connect from the top level; both memory clock inputs are tied to the same clk.

---
 rtl/fifo_ctrl.sv | 103 ++++++++++
 tb/tb_fifo_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for a single-clock FIFO memory of Depth entries.
// Optional almost_full/almost_empty outputs are enabled with `define FIFO_ALMOST_FLAGS_EN.
`timescale 1ns/1ps
module fifo_ctrl #(
   parameter int S     = 8,
   parameter int Depth = 150
`ifdef FIFO_ALMOST_FLAGS_EN
   ,
   parameter int AF_LVL = Depth - 4,
   parameter int AE_LVL = 4
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_req,
   input  logic         rd_req,
   output logic         wr_en,
   output logic [S-1:0] wr_ptr,
   output logic [S-1:0] rd_ptr,
   output logic         rd_valid,
   output logic         full,
   output logic         empty,
   output logic [S-1:0] count,
`ifdef FIFO_ALMOST_FLAGS_EN
   output logic         almost_full,
   output logic         almost_empty,
`endif
   output logic         wr_err,
   output logic         rd_err
);

   localparam logic [S-1:0] LAST    = S'(Depth - 1);
   localparam logic [S-1:0] DEPTH_V = S'(Depth);

   logic         rd_acc;
   logic         wr_acc;
   logic [S-1:0] wr_ptr_next;
   logic [S-1:0] rd_ptr_next;
   logic [S-1:0] count_next;
   logic         wr_err_next;
   logic         rd_err_next;

   // Flags come straight from the registered count so they never glitch on requests.
   always_comb begin
      empty = (count == '0);
      full  = (count == DEPTH_V);
   end

`ifdef FIFO_ALMOST_FLAGS_EN
   always_comb begin
      almost_full  = (int'(count) >= AF_LVL);
      almost_empty = (int'(count) <= AE_LVL);
   end
`endif

   // A write while full only fits if a read frees a slot on the same edge.
   always_comb begin
      rd_acc = rd_req & ~empty;
      wr_acc = wr_req & (~full | rd_acc);
      wr_en  = wr_acc;
   end

   always_comb begin
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      count_next  = count;
      wr_err_next = wr_req & ~wr_acc;
      rd_err_next = rd_req & ~rd_acc;

      // Depth need not be a power of two, so wrap explicitly at the last entry.
      if (wr_acc) begin
         wr_ptr_next = (wr_ptr == LAST) ? '0 : wr_ptr + S'(1);
      end
      if (rd_acc) begin
         rd_ptr_next = (rd_ptr == LAST) ? '0 : rd_ptr + S'(1);
      end

      case ({wr_acc, rd_acc})
         2'b10:   count_next = count + S'(1);
         2'b01:   count_next = count - S'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
         wr_err   <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_next;
         rd_ptr   <= rd_ptr_next;
         count    <= count_next;
         rd_valid <= rd_acc;
         wr_err   <= wr_err_next;
         rd_err   <= rd_err_next;
      end
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: behavioural memory plus a queue-based reference model.
`timescale 1ns/1ps
module tb_fifo_ctrl;

   localparam int S     = 8;
   localparam int DEPTH = 150;
   localparam int AF    = DEPTH - 4;
   localparam int AE    = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_req;
   logic         rd_req;
   logic         wr_en;
   logic [S-1:0] wr_ptr;
   logic [S-1:0] rd_ptr;
   logic         rd_valid;
   logic         full;
   logic         empty;
   logic [S-1:0] count;
   logic         wr_err;
   logic         rd_err;
`ifdef FIFO_ALMOST_FLAGS_EN
   logic         almost_full;
   logic         almost_empty;
`endif

   logic [7:0]   wr_data;
   logic [7:0]   rd_data;
   logic [7:0]   mem [0:DEPTH-1];

   int           n_checks = 0;
   int           n_fail   = 0;

   logic [7:0]   q [$];
   int           wr_cnt;
   int           rd_cnt;

   fifo_ctrl #(.S(S), .Depth(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .wr_req(wr_req),
      .rd_req(rd_req),
      .wr_en(wr_en),
      .wr_ptr(wr_ptr),
      .rd_ptr(rd_ptr),
      .rd_valid(rd_valid),
      .full(full),
      .empty(empty),
      .count(count),
`ifdef FIFO_ALMOST_FLAGS_EN
      .almost_full(almost_full),
      .almost_empty(almost_empty),
`endif
      .wr_err(wr_err),
      .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   // Memory with registered read, both ports clocked by clk.
   always @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
      rd_data <= mem[rd_ptr];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state();
      chk("count", 32'(count), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("wr_ptr", 32'(wr_ptr), 32'(wr_cnt));
      chk("rd_ptr", 32'(rd_ptr), 32'(rd_cnt));
`ifdef FIFO_ALMOST_FLAGS_EN
      chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
`endif
   endtask

   // One clock: apply requests after a falling edge, check, then check registered results.
   task automatic step(input bit w, input bit r, input logic [7:0] d);
      bit         e_empty;
      bit         e_full;
      bit         racc;
      bit         wacc;
      logic [7:0] e_rd;
      e_rd    = 8'h00;
      wr_req  = w;
      rd_req  = r;
      wr_data = d;
      e_empty = (q.size() == 0);
      e_full  = (q.size() == DEPTH);
      racc    = r && !e_empty;
      wacc    = w && (!e_full || racc);
      #1;
      chk("wr_en", 32'(wr_en), 32'(wacc));
      chk_state();
      if (racc) begin
         e_rd   = q.pop_front();
         rd_cnt = (rd_cnt + 1) % DEPTH;
      end
      if (wacc) begin
         q.push_back(d);
         wr_cnt = (wr_cnt + 1) % DEPTH;
      end
      @(posedge clk);
      #1;
      chk("rd_valid", 32'(rd_valid), 32'(racc));
      chk("wr_err", 32'(wr_err), 32'(w && !wacc));
      chk("rd_err", 32'(rd_err), 32'(r && !racc));
      if (racc) chk("rd_data", 32'(rd_data), 32'(e_rd));
      @(negedge clk);
      wr_req = 1'b0;
      rd_req = 1'b0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
      chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_wr_err", 32'(wr_err), 32'd0);
      chk("rst_rd_err", 32'(rd_err), 32'd0);
`ifdef FIFO_ALMOST_FLAGS_EN
      chk("rst_almost_full", 32'(almost_full), 32'd0);
      chk("rst_almost_empty", 32'(almost_empty), 32'd1);
`endif
   endtask

   initial begin
      bit w;
      bit r;
      int bias;
      rst     = 1'b1;
      wr_req  = 1'b0;
      rd_req  = 1'b0;
      wr_data = 8'h00;
      wr_cnt  = 0;
      rd_cnt  = 0;
      q.delete();
      repeat (2) @(negedge clk);
      #1;
      chk_reset_outputs();
      @(negedge clk);
      rst = 1'b0;

      // Three writes then three reads, data checked in order.
      step(1, 0, 8'h11);
      step(1, 0, 8'h22);
      step(1, 0, 8'h33);
      step(0, 1, 8'h00);
      step(0, 1, 8'h00);
      step(0, 1, 8'h00);
      chk_state();

      // Empty with both requests: write wins, read rejected.
      step(1, 1, 8'hA5);
      step(0, 1, 8'h00);

      // Fill to full, then reject an extra write.
      for (int i = 0; i < DEPTH; i++) step(1, 0, 8'($urandom));
      step(1, 0, 8'hEE);
      step(1, 0, 8'hEF);

      // Full with both requests: count holds, both pointers move.
      step(1, 1, 8'h5A);
      step(1, 1, 8'h5B);

      // Drain completely, then an extra read is rejected.
      for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00);
      step(0, 1, 8'h00);
      chk_state();

      // Mid-level simultaneous traffic holds the count.
      for (int i = 0; i < 75; i++) step(1, 0, 8'($urandom));
      for (int i = 0; i < 4; i++) step(1, 1, 8'($urandom));
      chk_state();

      // Randomised traffic with drifting write bias to visit both full and empty.
      bias = 70;
      for (int i = 0; i < 1500; i++) begin
         if (i % 250 == 0) bias = (bias == 70) ? 30 : 70;
         w = ($urandom_range(0, 99) < bias);
         r = ($urandom_range(0, 99) < (100 - bias));
         step(w, r, 8'($urandom));
      end

      // Settle at 40 entries, read, then reset asynchronously while rd_valid is high.
      while (q.size() > 40) step(0, 1, 8'h00);
      while (q.size() < 40) step(1, 0, 8'($urandom));
      step(1, 1, 8'h77);
      chk("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
      chk("pre_rst_count", 32'(count), 32'd40);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      wr_cnt = 0;
      rd_cnt = 0;
      step(1, 0, 8'h3C);
      step(0, 1, 8'h00);
      chk_state();

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
